if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU: owns the PC register, the instruction-memory request handshake, a one-entry fetch buffer and the IF/ID pipeline register. It sits directly upstream of the load-use hazard detector, which consumes `ifid_rs_o`/`ifid_rt_o`. The hazard detector's PC/IF-ID stall outputs feed back into this stage. Branch/jump redirects from later stages flush the stage and reload the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0000: instruction word placed in IF/ID when it holds a bubble.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `pc_stall_i`  in  1  PC stall from the hazard detector.
- `ifid_stall_i`  in  1  IF/ID stall from the hazard detector.
- `flush_i`  in  1  taken branch/jump; squash IF/ID and redirect.
- `redirect_pc_i`  in  32  new PC, valid when `flush_i`=1.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address (current PC).
- `imem_ready_i`  in  1  fetch completes this cycle; data valid.
- `imem_data_i`  in  32  fetched instruction.
- `ifid_pc4_o`  out  32  PC+4 of the instruction in IF/ID.
- `ifid_instr_o`  out  32  instruction in IF/ID.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `ifid_rs_o`  out  5  `ifid_instr_o[25:21]`, combinational.
- `ifid_rt_o`  out  5  `ifid_instr_o[20:16]`, combinational.

## Operation
- `stall` = `pc_stall_i | ifid_stall_i`. Either input freezes the stage.
- FSM states: IDLE, FETCH, BUF.
  - IDLE is the reset state with `imem_req_o`=0. IDLE always goes to FETCH on the next cycle.
  - FETCH drives `imem_req_o`=1 and `imem_addr_o`=PC.
  - BUF drives `imem_req_o`=0 and holds one fetched instruction in the buffer (`buf_instr`, `buf_pc4`).
- Priority per cycle: `flush_i` first, then `stall`, then normal operation.
- Flush, from any state:
  - PC <= `{redirect_pc_i[31:2],2'b00}`.
  - IF/ID <= {pc4=0, `NOP_INSTR`, valid=0}.
  - Buffer is discarded; state goes to FETCH.
  - An `imem_ready_i` arriving in the same cycle is ignored.
- FETCH, ready=1, stall=0: IF/ID <= {PC+4, `imem_data_i`, 1}; PC <= PC+4.
- FETCH, ready=1, stall=1: buffer <= {`imem_data_i`, PC+4}; PC <= PC+4; state goes to BUF; IF/ID holds.
- FETCH, ready=0, stall=0: IF/ID <= {0, `NOP_INSTR`, 0} (bubble); PC holds.
- FETCH, ready=0, stall=1: everything holds.
- BUF, stall=0: IF/ID <= {`buf_pc4`, `buf_instr`, 1}; state goes to FETCH; PC holds. It already points past the buffered instruction.
- BUF, stall=1: everything holds.
- Arithmetic: PC+4 is a 32-bit add modulo 2^32. 32'hFFFF_FFFC + 4 = 0, with no error.
- Bubble contents: a bubble in IF/ID has rs/rt fields taken from `NOP_INSTR`. With the default these are 0, so the hazard detector may stall on a bubble; this is harmless.

## Timing
- Reset, asynchronous while `rst_i`=0:
  - PC = `RESET_PC`, state = IDLE.
  - `imem_req_o`=0, `ifid_pc4_o`=0, `ifid_instr_o`=`NOP_INSTR`, `ifid_valid_o`=0.
  - Buffer = 0.
- Reset asserted mid-fetch aborts the outstanding request immediately; no IF/ID update occurs.
- First request is issued the 2nd rising edge after reset release: IDLE lasts 1 cycle.
- Latency: with `imem_ready_i` tied high, the instruction at address A appears in IF/ID one cycle after A is on `imem_addr_o`. Throughput is 1 instruction per cycle.
- Load-use stall of one cycle with ready tied high:
  - The next instruction is captured in the buffer while stalled.
  - It is released the following cycle; no fetch is issued in BUF.
  - No extra bubble is introduced.
- Flush latency: `redirect_pc_i` appears on `imem_addr_o` the cycle after `flush_i`, and IF/ID valid=0 in that same cycle.
- Flush together with stall: flush wins. Stall is ignored that cycle.
- All outputs except `ifid_rs_o`/`ifid_rt_o` are registered. `imem_req_o` decodes state only and has no input-to-output path.

## Test plan
- Reset then ready=1, no stall -> `imem_addr_o` = 0,4,8,… one per cycle. IF/ID shows `ifid_pc4_o` 4,8,12 with valid=1 starting 2 cycles after reset release.
- Load-use: both stalls high for 1 cycle while instr@8 is in IF/ID -> IF/ID holds instr@8. Instr@12 goes to the buffer, then to IF/ID next cycle; instr@16 is fetched the cycle after. No instruction is lost or duplicated.
- Slow memory, ready low 3 cycles at PC=0x20 -> 3 bubbles (valid=0, instr=`NOP_INSTR`). Address stays 0x20, then instr@0x20 enters with pc4=0x24.
- Flush with `redirect_pc_i`=0x103 while in BUF and ready=1 -> next cycle `imem_addr_o`=0x100, IF/ID valid=0. Buffered instruction never appears.
- PC wrap: redirect to 0xFFFF_FFFC, ready=1 -> `ifid_pc4_o`=0 and the next `imem_addr_o`=0.
- Assert `rst_i`=0 asynchronously mid-stall in BUF -> outputs return to reset values before the next clock edge. The fetch sequence then restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request handshake, one-entry
// fetch buffer for fetches that land while the pipe is stalled, IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_stall_i,
    input  logic        ifid_stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [4:0]  ifid_rs_o,
    output logic [4:0]  ifid_rt_o
);

    typedef enum logic [1:0] {IDLE, FETCH, BUF} state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fbuf_t;

    localparam ifid_t BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    fbuf_t       buf_q, buf_d;
    logic        stall;
    logic [31:0] pc4;

    assign stall = pc_stall_i | ifid_stall_i;
    assign pc4   = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        buf_d   = buf_q;
        if (flush_i) begin
            // Any fetch completing this cycle belongs to the squashed path.
            pc_d    = redirect_pc_i & ~32'd3;
            ifid_d  = BUBBLE;
            buf_d   = '0;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ready_i && !stall) begin
                        ifid_d = '{pc4: pc4, instr: imem_data_i, valid: 1'b1};
                        pc_d   = pc4;
                    end else if (imem_ready_i) begin
                        // Park the word so the downstream stall costs no refetch.
                        buf_d   = '{instr: imem_data_i, pc4: pc4};
                        pc_d    = pc4;
                        state_d = BUF;
                    end else if (!stall) begin
                        ifid_d = BUBBLE;
                    end
                end
                BUF: begin
                    if (!stall) begin
                        ifid_d  = '{pc4: buf_q.pc4, instr: buf_q.instr, valid: 1'b1};
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= BUBBLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req_o   = (state_q == FETCH);
    assign imem_addr_o  = pc_q;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;
    assign ifid_rs_o    = ifid_q.instr[25:21];
    assign ifid_rt_o    = ifid_q.instr[20:16];

endmodule
